// File: rtl/linked_fifo_sched_pkg.sv
// linked_fifo_sched_pkg
//   Shared constants, types and helpers for the linked_fifo dequeue
//   scheduler. Imported by rr_arbiter and linked_fifo_sched.
//   - STAT_W      : width of the optional commit/revoke counters
//   - QNUM_DEF/QW : default queue count and matching queue-id width
//   - qid_t       : queue-id type for the default configuration; modules
//                   with a parameterised queue count declare a local
//                   qid_t of the same shape
//   - rr_next()   : wrap-around increment used to advance the RR pointer
package linked_fifo_sched_pkg;

    localparam int STAT_W   = 32;
    localparam int QNUM_DEF = 16;
    localparam int QW_DEF   = $clog2(QNUM_DEF);

    typedef logic [QW_DEF-1:0] qid_t;
    typedef logic [STAT_W-1:0] stat_t;

    // Returns ptr + 1, wrapping to 0 when it reaches n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin picker. The lowest requesting index
//   at or above ptr wins; if none exists, the lowest requesting index
//   overall wins (wrap-around). The pointer itself lives in the parent.
//   Ports:
//     req     in  N   request vector
//     ptr     in  W   round-robin start index
//     gnt_vld out 1   at least one request present
//     gnt_idx out W   winning index (0 when gnt_vld = 0)
module rr_arbiter
    import linked_fifo_sched_pkg::*;
#(
    parameter int  N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    logic [N-1:0] req_hi;

    // Masked double-priority encode: first look only at indices >= ptr,
    // fall back to the unmasked vector to model the wrap.
    // NOTE: every signal written in always_comb gets a default at the top
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        req_hi  = '0;
        gnt_vld = |req;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            req_hi[i] = req[i] && (i >= int'(ptr));
        end
        // Scanning from the top down leaves the lowest hit in gnt_idx.
        if (|req_hi) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_hi[i]) gnt_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) gnt_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/linked_fifo_sched.sv
// linked_fifo_sched
//   Enqueue front-end and dequeue scheduler for the multi-queue linked_fifo.
//   Each cycle it issues at most one dequeue, round-robin among non-empty
//   queues whose consumer is ready. The data returns one cycle later; if
//   the consumer dropped ready meanwhile, the dequeue is cancelled with
//   f_revoke (which also blocks enqueue and issue for that cycle).
//
//   Optional build macro: LINKED_FIFO_SCHED_STATS_EN adds two saturating
//   counters, stat_commit and stat_revoke. Scheduling is unaffected.
//
//   Ports:
//     clk, rstn                   clock, async active-low reset
//     in_vld/in_rdy/in_qid/in_data upstream enqueue handshake
//     f_enq/f_enqid/f_enqData     enqueue request to FIFO
//     f_enqRdy_r                  FIFO has room (registered)
//     f_deq/f_deqid/f_revoke      dequeue request / cancel to FIFO
//     f_deqVld_r                  per-queue non-empty from FIFO
//     f_dataVld/f_deqData         registered dequeue data from FIFO
//     out_rdy                     per-queue consumer ready
//     out_vld/out_qid/out_data    delivery to consumer (must be taken)
//     stat_commit/stat_revoke     counters (only with the macro)
module linked_fifo_sched
    import linked_fifo_sched_pkg::*;
#(
    parameter int  QNUM    = 16,
    parameter int  PAYLOAD = 32,
    localparam int QW      = $clog2(QNUM)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [QW-1:0]      in_qid,
    input  logic [PAYLOAD-1:0] in_data,
    output logic               f_enq,
    output logic [QW-1:0]      f_enqid,
    output logic [PAYLOAD-1:0] f_enqData,
    input  logic               f_enqRdy_r,
    output logic               f_deq,
    output logic [QW-1:0]      f_deqid,
    output logic               f_revoke,
    input  logic [QNUM-1:0]    f_deqVld_r,
    input  logic               f_dataVld,
    input  logic [PAYLOAD-1:0] f_deqData,
    input  logic [QNUM-1:0]    out_rdy,
    output logic               out_vld,
    output logic [QW-1:0]      out_qid,
`ifdef LINKED_FIFO_SCHED_STATS_EN
    output logic [STAT_W-1:0]  stat_commit,
    output logic [STAT_W-1:0]  stat_revoke,
`endif
    output logic [PAYLOAD-1:0] out_data
);

    typedef logic [QW-1:0] lqid_t;

    logic      pend_vld_q, pend_vld_d;
    lqid_t     pend_qid_q, pend_qid_d;
    lqid_t     rr_ptr_q,   rr_ptr_d;

    logic            resolve;
    logic            commit;
    logic            revoke_now;
    lqid_t           arb_ptr;
    logic [QNUM-1:0] elig;
    logic            gnt_vld;
    lqid_t           gnt_idx;

    // Resolution of last cycle's dequeue and the pointer used for this
    // cycle's pick. When the pending entry resolves now, the pointer is
    // forwarded (pend_qid + 1) so back-to-back issues rotate immediately
    // instead of re-picking the queue just served.
    always_comb begin
        resolve    = pend_vld_q && f_dataVld;
        commit     = resolve && out_rdy[pend_qid_q];
        revoke_now = resolve && !out_rdy[pend_qid_q];
        arb_ptr    = resolve ? QW'(rr_next(32'(pend_qid_q), QNUM)) : rr_ptr_q;
        // The FIFO ignores deq during a revoke, so nothing is eligible then.
        elig       = f_deqVld_r & out_rdy & ~{QNUM{revoke_now}};
    end

    rr_arbiter #(.N(QNUM)) u_arb (
        .req     (elig),
        .ptr     (arb_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Next state. A pending entry with no returned data is dropped without
    // revoke and leaves the pointer where it was.
    always_comb begin
        rr_ptr_d   = arb_ptr;
        pend_vld_d = gnt_vld;
        pend_qid_d = gnt_vld ? gnt_idx : pend_qid_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_vld_q <= 1'b0;
            pend_qid_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_qid_q <= pend_qid_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Outputs.
    always_comb begin
        f_deq     = gnt_vld;
        f_deqid   = gnt_idx;
        f_revoke  = revoke_now;
        in_rdy    = f_enqRdy_r && !revoke_now;
        f_enq     = in_vld && in_rdy;
        f_enqid   = in_qid;
        f_enqData = in_data;
        out_vld   = commit;
        out_qid   = pend_qid_q;
        out_data  = f_deqData;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn && pend_vld_q && !f_dataVld) begin
            $error("linked_fifo_sched: no f_dataVld for pending dequeue of q%0d", pend_qid_q);
        end
    end
`endif

`ifdef LINKED_FIFO_SCHED_STATS_EN
    stat_t stat_commit_q, stat_commit_d;
    stat_t stat_revoke_q, stat_revoke_d;

    // Saturating counters: hold at all-ones.
    always_comb begin
        stat_commit_d = stat_commit_q;
        stat_revoke_d = stat_revoke_q;
        if (commit && stat_commit_q != '1) stat_commit_d = stat_commit_q + STAT_W'(1);
        if (revoke_now && stat_revoke_q != '1) stat_revoke_d = stat_revoke_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_commit_q <= '0;
            stat_revoke_q <= '0;
        end else begin
            stat_commit_q <= stat_commit_d;
            stat_revoke_q <= stat_revoke_d;
        end
    end

    assign stat_commit = stat_commit_q;
    assign stat_revoke = stat_revoke_q;
`endif

endmodule

// File: tb/tb_linked_fifo_sched.sv
// tb_linked_fifo_sched
//   Bench for linked_fifo_sched. Contains a behavioural stand-in for the
//   linked_fifo (per-queue queues, registered outputs, revoke restores the
//   in-flight item), a reference scheduler model built from queues and a
//   linear round-robin search, a per-cycle compare on the falling edge, and
//   directed scenarios with literal expected delivery sequences.
module tb_linked_fifo_sched;
    import linked_fifo_sched_pkg::*;

    localparam int QNUM    = 16;
    localparam int PAYLOAD = 32;
    localparam int QW      = 4;
    localparam int CAP     = 8;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               in_vld = 1'b0;
    logic               in_rdy;
    logic [QW-1:0]      in_qid = '0;
    logic [PAYLOAD-1:0] in_data = '0;
    logic               f_enq;
    logic [QW-1:0]      f_enqid;
    logic [PAYLOAD-1:0] f_enqData;
    logic               f_enqRdy_r;
    logic               f_deq;
    logic [QW-1:0]      f_deqid;
    logic               f_revoke;
    logic [QNUM-1:0]    f_deqVld_r;
    logic               f_dataVld;
    logic [PAYLOAD-1:0] f_deqData;
    logic [QNUM-1:0]    out_rdy = '0;
    logic               out_vld;
    logic [QW-1:0]      out_qid;
    logic [PAYLOAD-1:0] out_data;
`ifdef LINKED_FIFO_SCHED_STATS_EN
    logic [STAT_W-1:0]  stat_commit;
    logic [STAT_W-1:0]  stat_revoke;
`endif

    always #5 clk = ~clk;

    linked_fifo_sched #(.QNUM(QNUM), .PAYLOAD(PAYLOAD)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_qid     (in_qid),
        .in_data    (in_data),
        .f_enq      (f_enq),
        .f_enqid    (f_enqid),
        .f_enqData  (f_enqData),
        .f_enqRdy_r (f_enqRdy_r),
        .f_deq      (f_deq),
        .f_deqid    (f_deqid),
        .f_revoke   (f_revoke),
        .f_deqVld_r (f_deqVld_r),
        .f_dataVld  (f_dataVld),
        .f_deqData  (f_deqData),
        .out_rdy    (out_rdy),
        .out_vld    (out_vld),
        .out_qid    (out_qid),
`ifdef LINKED_FIFO_SCHED_STATS_EN
        .stat_commit(stat_commit),
        .stat_revoke(stat_revoke),
`endif
        .out_data   (out_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO stand-in ----------------
    logic [PAYLOAD-1:0] fq [QNUM][$];
    logic               held_vld;
    logic [QW-1:0]      held_id;
    logic [PAYLOAD-1:0] held_data;
    // DUT requests captured on the falling edge, applied on the rising edge.
    logic               s_enq, s_deq, s_rev;
    logic [QW-1:0]      s_enqid, s_deqid;
    logic [PAYLOAD-1:0] s_enqdata;

    always @(posedge clk or negedge rstn) begin : fifo_model
        int occ;
        if (!rstn) begin
            for (int i = 0; i < QNUM; i++) fq[i].delete();
            held_vld = 1'b0;
            held_id = '0;
            held_data = '0;
            f_deqVld_r <= '0;
            f_dataVld  <= 1'b0;
            f_deqData  <= '0;
            f_enqRdy_r <= 1'b0;
        end else begin
            if (s_rev) begin
                if (held_vld) fq[held_id].push_front(held_data);
                held_vld = 1'b0;
                f_dataVld <= 1'b0;
            end else begin
                held_vld = 1'b0;
                if (s_deq && fq[s_deqid].size() != 0) begin
                    held_data = fq[s_deqid].pop_front();
                    held_id   = s_deqid;
                    held_vld  = 1'b1;
                    f_dataVld <= 1'b1;
                    f_deqData <= held_data;
                end else begin
                    f_dataVld <= 1'b0;
                end
                if (s_enq) fq[s_enqid].push_back(s_enqdata);
            end
            occ = held_vld ? 1 : 0;
            for (int i = 0; i < QNUM; i++) begin
                occ += fq[i].size();
                f_deqVld_r[i] <= (fq[i].size() != 0);
            end
            f_enqRdy_r <= (occ < CAP);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic               m_pend_vld;
    int                 m_pend_qid;
    int                 m_ptr;
    logic [PAYLOAD-1:0] sb [QNUM][$];
    int                 m_commits, m_revokes;

    // Logs of what the DUT actually did, for literal checks.
    logic [QW-1:0]      dl_q [$];
    logic [PAYLOAD-1:0] dl_d [$];
    int                 dl_c [$];
    int                 iss_log [$];
    int                 rev_cnt, rev_inrdy, acc_cnt, blocked, first_rdy;
    int                 cyc = 0;

    always @(negedge clk) begin : mon
        logic               e_commit, e_revoke, e_deq, e_in_rdy, e_enq;
        logic [PAYLOAD-1:0] e_data;
        int                 e_win, qq;
        if (!rstn) begin
            m_pend_vld = 1'b0;
            m_pend_qid = 0;
            m_ptr      = 0;
            m_commits  = 0;
            m_revokes  = 0;
            for (int i = 0; i < QNUM; i++) sb[i].delete();
            s_enq = 1'b0; s_deq = 1'b0; s_rev = 1'b0;
            s_enqid = '0; s_deqid = '0; s_enqdata = '0;
        end else begin
            e_commit = m_pend_vld && out_rdy[m_pend_qid];
            e_revoke = m_pend_vld && !out_rdy[m_pend_qid];
            if (m_pend_vld) m_ptr = (m_pend_qid + 1) % QNUM;
            e_win = -1;
            if (!e_revoke) begin
                for (int k = 0; k < QNUM; k++) begin
                    qq = (m_ptr + k) % QNUM;
                    if (e_win < 0 && f_deqVld_r[qq] && out_rdy[qq]) e_win = qq;
                end
            end
            e_deq    = (e_win >= 0);
            e_in_rdy = f_enqRdy_r && !e_revoke;
            e_enq    = in_vld && e_in_rdy;

`ifdef LINKED_FIFO_SCHED_STATS_EN
            check("stat_commit", stat_commit, m_commits);
            check("stat_revoke", stat_revoke, m_revokes);
`endif
            check("out_vld", out_vld, e_commit);
            if (e_commit) begin
                e_data = (sb[m_pend_qid].size() != 0) ? sb[m_pend_qid].pop_front() : 'x;
                check("out_qid", out_qid, m_pend_qid);
                check("out_data", out_data, e_data);
                m_commits++;
            end
            check("f_revoke", f_revoke, e_revoke);
            if (e_revoke) m_revokes++;
            check("f_deq", f_deq, e_deq);
            if (e_deq) check("f_deqid", f_deqid, e_win);
            check("in_rdy", in_rdy, e_in_rdy);
            check("f_enq", f_enq, e_enq);
            if (e_enq) begin
                check("f_enqid", f_enqid, in_qid);
                check("f_enqData", f_enqData, in_data);
                sb[in_qid].push_back(in_data);
            end
            m_pend_vld = e_deq;
            if (e_deq) m_pend_qid = e_win;

            if (out_vld) begin
                dl_q.push_back(out_qid);
                dl_d.push_back(out_data);
                dl_c.push_back(cyc);
            end
            if (f_deq) iss_log.push_back(int'(f_deqid));
            if (f_revoke) begin
                rev_cnt++;
                rev_inrdy = int'(in_rdy);
            end
            if (f_enq) acc_cnt++;
            if (in_vld && !in_rdy) blocked++;
            if (in_vld && in_rdy && first_rdy < 0) first_rdy = cyc;

            s_enq = f_enq; s_deq = f_deq; s_rev = f_revoke;
            s_enqid = f_enqid; s_deqid = f_deqid; s_enqdata = f_enqData;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input int q, input logic [31:0] d, input logic [15:0] rdy);
        @(posedge clk);
        #1;
        in_vld  = v;
        in_qid  = QW'(q);
        in_data = d;
        out_rdy = rdy;
    endtask

    task automatic idle(input int n, input logic [15:0] rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 32'h0, rdy);
    endtask

    task automatic clear_logs();
        dl_q.delete(); dl_d.delete(); dl_c.delete(); iss_log.delete();
        rev_cnt = 0; rev_inrdy = -1; acc_cnt = 0; blocked = 0; first_rdy = -1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0; in_vld = 1'b0; out_rdy = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2, 16'h0000);
    endtask

    int ph_start;

    initial begin
        clear_logs();
        // Reset state, with requests pending on the inputs.
        in_vld = 1'b1; out_rdy = '1;
        #12;
        check("rst_out_vld", out_vld, 0);
        check("rst_f_deq", f_deq, 0);
        check("rst_f_revoke", f_revoke, 0);
        check("rst_f_enq", f_enq, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_rr_ptr", dut.rr_ptr_q, 0);
        check("rst_pend_vld", dut.pend_vld_q, 0);
        check("rst_pend_qid", dut.pend_qid_q, 0);
`ifdef LINKED_FIFO_SCHED_STATS_EN
        check("rst_stat_commit", stat_commit, 0);
        check("rst_stat_revoke", stat_revoke, 0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1; in_vld = 1'b0; out_rdy = '0;
        idle(2, 16'h0000);

        // 1. Single queue, consumer always ready.
        clear_logs();
        step(1'b1, 2, 32'hA000_0001, '1);
        step(1'b1, 2, 32'hA000_0002, '1);
        step(1'b1, 2, 32'hA000_0003, '1);
        idle(5, '1);
        check("single_count", dl_d.size(), 3);
        if (dl_d.size() == 3) begin
            check("single_q0", dl_q[0], 2);
            check("single_q2", dl_q[2], 2);
            check("single_d0", dl_d[0], 32'hA000_0001);
            check("single_d1", dl_d[1], 32'hA000_0002);
            check("single_d2", dl_d[2], 32'hA000_0003);
            check("single_consecutive", dl_c[2] - dl_c[0], 2);
        end

        // 2. Round-robin across q0, q3, q7 (pointer starts at 0).
        do_reset();
        clear_logs();
        step(1'b1, 0, 32'hB000_0000, '0);
        step(1'b1, 3, 32'hB000_0001, '0);
        step(1'b1, 7, 32'hB000_0002, '0);
        step(1'b1, 0, 32'hB000_0003, '0);
        step(1'b1, 3, 32'hB000_0004, '0);
        step(1'b1, 7, 32'hB000_0005, '0);
        idle(1, '0);
        idle(9, '1);
        check("rr_count", dl_q.size(), 6);
        if (dl_q.size() == 6) begin
            check("rr_seq0", dl_q[0], 0);
            check("rr_seq1", dl_q[1], 3);
            check("rr_seq2", dl_q[2], 7);
            check("rr_seq3", dl_q[3], 0);
            check("rr_seq4", dl_q[4], 3);
            check("rr_seq5", dl_q[5], 7);
            check("rr_data4", dl_d[4], 32'hB000_0004);
        end

        // 3. Revoke of q5, then clean redelivery of A then B.
        clear_logs();
        step(1'b1, 5, 32'h0000_00AA, '0);
        step(1'b1, 5, 32'h0000_00BB, '0);
        idle(1, '0);
        step(1'b0, 0, 32'h0, 16'h0020);
        step(1'b1, 9, 32'h0000_00CC, 16'h0000);
        idle(4, 16'h0020);
        check("rev_count", rev_cnt, 1);
        check("rev_in_rdy", rev_inrdy, 0);
        check("rev_no_enq", acc_cnt, 2);
        check("rev_deliv_count", dl_d.size(), 2);
        if (dl_d.size() == 2) begin
            check("rev_deliv_q", dl_q[0], 5);
            check("rev_deliv_a", dl_d[0], 32'h0000_00AA);
            check("rev_deliv_b", dl_d[1], 32'h0000_00BB);
        end

        // 4. Revoke fairness: q1 revoked, q2 must be issued next.
        clear_logs();
        step(1'b1, 1, 32'h0000_0011, '0);
        step(1'b1, 2, 32'h0000_0022, '0);
        idle(1, '0);
        step(1'b0, 0, 32'h0, 16'h0006);
        step(1'b0, 0, 32'h0, 16'h0004);
        idle(4, 16'h0006);
        check("fair_revoke", rev_cnt, 1);
        check("fair_issue_count", iss_log.size(), 3);
        if (iss_log.size() == 3) begin
            check("fair_first", iss_log[0], 1);
            check("fair_after_revoke", iss_log[1], 2);
        end
        if (dl_q.size() == 2) begin
            check("fair_deliv0", dl_q[0], 2);
            check("fair_deliv1", dl_q[1], 1);
        end else begin
            check("fair_deliv_count", dl_q.size(), 2);
        end

        // 5. Full: occupancy reaches CAP, then a commit reopens the input.
        clear_logs();
        for (int i = 0; i < 10; i++) step(1'b1, 4, 32'hD000_0000 + i, '0);
        check("full_accepted", acc_cnt, CAP);
        check("full_blocked", blocked != 0, 1);
        check("full_in_rdy_low", in_rdy, 0);
        step(1'b1, 4, 32'hE000_0000, 16'h0010);
        ph_start = cyc;
        first_rdy = -1;
        for (int i = 1; i < 6; i++) step(1'b1, 4, 32'hE000_0000 + i, 16'h0010);
        check("full_reopen_delay", first_rdy - ph_start, 2);
        idle(14, '1);
        check("full_total_accepted", acc_cnt, 12);
        check("full_all_delivered", dl_d.size(), acc_cnt);
        check("full_sb_empty", sb[4].size(), 0);

        // 6. Reset while a dequeue is pending.
        clear_logs();
        step(1'b1, 6, 32'h0000_0061, '0);
        step(1'b1, 6, 32'h0000_0062, '0);
        idle(1, '0);
        step(1'b1, 6, 32'h0000_0063, '1);
        @(posedge clk);
        #1;
        check("mid_pending", dut.pend_vld_q, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_out_vld", out_vld, 0);
        check("mid_f_deq", f_deq, 0);
        check("mid_f_revoke", f_revoke, 0);
        check("mid_f_enq", f_enq, 0);
        check("mid_in_rdy", in_rdy, 0);
        check("mid_rr_ptr", dut.rr_ptr_q, 0);
        check("mid_pend_vld", dut.pend_vld_q, 0);
`ifdef LINKED_FIFO_SCHED_STATS_EN
        check("mid_stat_commit", stat_commit, 0);
        check("mid_stat_revoke", stat_revoke, 0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1; in_vld = 1'b0; out_rdy = '0;
        idle(2, '0);
        clear_logs();
        step(1'b1, 9, 32'h0000_0F00, '0);
        step(1'b1, 3, 32'h0000_0F01, '0);
        idle(1, '0);
        idle(4, '1);
        check("post_rst_count", dl_q.size(), 2);
        if (dl_q.size() == 2) begin
            check("post_rst_first", dl_q[0], 3);
            check("post_rst_second", dl_q[1], 9);
            check("post_rst_data", dl_d[0], 32'h0000_0F01);
        end

        idle(2, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/linked_fifo_sched.md
# linked_fifo_sched

Dequeue scheduler and enqueue front-end for the multi-queue `linked_fifo`. It accepts upstream enqueue beats and forwards them into the FIFO. It picks one non-empty queue per cycle, round-robin among queues whose downstream consumer is ready, and issues the FIFO dequeue. If the consumer is no longer ready when the data returns one cycle later, it cancels that dequeue with `revoke`.

## Interface
- `QNUM`, 16: number of queues; `QW = $clog2(QNUM)`.
- `PAYLOAD`, 32: data width.
- `clk`  in  1: clock.
- `rstn`  in  1: reset; **one clock; reset is asynchronous and active-low.**
- `in_vld`  in  1: upstream enqueue request.
- `in_rdy`  out  1: enqueue accepted when `in_vld & in_rdy`.
- `in_qid`  in  QW: target queue.
- `in_data`  in  PAYLOAD: payload.
- `f_enq`  out  1: to FIFO `enq`.
- `f_enqid`  out  QW: to FIFO `enqid`.
- `f_enqData`  out  PAYLOAD: to FIFO `enqData`.
- `f_enqRdy_r`  in  1: from FIFO `enqRdy_r`.
- `f_deq`  out  1: to FIFO `deq`.
- `f_deqid`  out  QW: to FIFO `deqid`.
- `f_revoke`  out  1: to FIFO `revoke`.
- `f_deqVld_r`  in  QNUM: from FIFO, per-queue non-empty.
- `f_dataVld`  in  1: from FIFO.
- `f_deqData`  in  PAYLOAD: from FIFO.
- `out_rdy`  in  QNUM: per-queue consumer ready.
- `out_vld`  out  1: delivery strobe; the consumer must take it.
- `out_qid`  out  QW: queue of the delivered item.
- `out_data`  out  PAYLOAD: delivered payload.

## Operation
- Eligibility: `elig = f_deqVld_r & out_rdy & ~{QNUM{revoke_now}}`.
- Arbitration: round-robin starting at pointer `rr_ptr`. The lowest eligible index at or after `rr_ptr` wins, wrapping from QNUM-1 to 0.
- Issue cycle N: if `elig != 0`, then `f_deq = 1`, `f_deqid = winner`, and the pending register loads `{pend_vld = 1, pend_qid = winner}`.
- Cycle N+1, pending and `out_rdy[pend_qid] = 1` (commit):
  - `out_vld = 1`, `out_qid = pend_qid`, `out_data = f_deqData`.
  - `rr_ptr <= pend_qid + 1`, taken modulo QNUM.
- Cycle N+1, pending and `out_rdy[pend_qid] = 0` (revoke):
  - `f_revoke = 1`, `out_vld = 0`.
  - `rr_ptr <= pend_qid + 1`, so the revoked queue is not retried first.
- Revoke cycle: the FIFO ignores `enq` and `deq`. The block therefore forces `f_deq = 0`, `f_enq = 0` and `in_rdy = 0`.
- Enqueue path:
  - `in_rdy = f_enqRdy_r & ~revoke_now`.
  - `f_enq = in_vld & in_rdy`.
  - `f_enqid` and `f_enqData` pass through from `in_qid` and `in_data`.
- Simultaneous enqueue and dequeue of the same queue is legal. The FIFO resolves it.
- `f_dataVld = 0` while a dequeue is pending is a protocol error. Under simulation: `$error`, drop the pending entry, emit no revoke.
- Back-to-back dequeues of the same queue are allowed, because `f_deqVld_r` is already updated at N+1.

## Timing
- Reset values:
  - `f_deq`, `f_revoke`, `f_enq`, `out_vld`, `pend_vld` = 0.
  - `rr_ptr` = 0, `pend_qid` = 0.
  - `in_rdy` = 0, since `f_enqRdy_r` resets to 0.
- Issue-to-delivery latency is 1 cycle. Peak throughput is 1 item per cycle.
- A revoke costs one bubble cycle: no issue and no enqueue in that cycle.
- `out_vld` depends combinationally on `out_rdy`. `out_data` comes straight from the registered FIFO output.
- Reset mid-operation drops the pending dequeue. The FIFO is reset by the same `rstn`.

## Configuration
- `LINKED_FIFO_SCHED_STATS_EN` defined: adds two 32-bit saturating output counters.
  - `stat_commit`: increments on each commit.
  - `stat_revoke`: increments on each revoke.
  - Both reset to 0 and hold at 0xFFFF_FFFF.
- Not defined: the ports and logic are absent. Scheduling behaviour is identical either way.

## Structure
- `linked_fifo_sched_pkg` holds:
  - `STAT_W = 32`.
  - Function `rr_next(ptr, n)`: wrap-around increment.
  - The shared QW typedef pattern.
- Sub-module `rr_arbiter #(N)`: inputs `req`, `ptr`; outputs `gnt_vld`, `gnt_idx`.
  - Implemented as masked double-priority encode.
  - Purely combinational; `rr_ptr` lives in the parent.
- Expected size: about 200 lines.

## Test plan
- Single queue: enqueue 3 items to q2 with `out_rdy = '1` → `out_vld` on 3 consecutive cycles, `out_qid = 2`, data in FIFO order.
- Round-robin: q0, q3 and q7 each hold 2 items, all ready → `out_qid` sequence 0,3,7,0,3,7.
- Revoke: q5 holds A, B. Drop `out_rdy[5]` in the cycle after issue → `f_revoke = 1` and `in_rdy = 0` that cycle. After re-raise, q5 delivers A then B with no loss or duplication.
- Revoke fairness: q1 and q2 are non-empty and q1's first issue is revoked → the next issue is q2, not q1.
- Full: fill until `f_enqRdy_r = 0` → `in_rdy = 0` and no `f_enq`. One commit frees space, then `in_rdy` returns to 1.
- Reset mid-operation: assert `rstn = 0` during the pending cycle → all outputs 0 and `rr_ptr = 0`. With the stats macro defined, the counters read 0.
